// File: rtl/fft_spectrum_packer.sv
// rtl/fft_spectrum_packer.sv - captures one FFT frame, packs bin magnitudes and peak, streams them as UART bytes
module fft_spectrum_packer #(
  parameter int POINTS    = 1024,
  parameter int HALF      = POINTS / 2,
  parameter int MAG_SHIFT = 9
) (
  input  logic        clk_24M_from_pll,
  input  logic        rst_24M_n,
  input  logic        arm,
  input  logic        s_tvalid,
  input  logic [47:0] s_tdata,
  input  logic        s_tlast,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        busy,
  output logic        frame_done,
  output logic        err_len,
  output logic [7:0]  drop_cnt
);
  localparam int          AW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [15:0] LAST_BEAT = 16'(POINTS - 1);
  localparam logic [15:0] HALF_BINS = 16'(HALF);
  localparam logic [16:0] DATA_END  = 17'(2 * HALF + 5);
  localparam logic [16:0] LAST_BYTE = 17'(2 * HALF + 6);

  typedef enum logic [2:0] {IDLE, CAPTURE, SEND, GUARD, WAITTX} state_t;
  state_t state, state_nx;

  logic        take_first, take_beat, at_last, bad_len, frame_end, pipe_in;
  logic        last_byte, send_now, advance, in_data, dropped;
  logic [15:0] beat_cnt, bin1, bin2, peak_bin, peak_mag, mag16, rd_word;
  logic        drain, drain_cnt, guard_cnt, lo_sel, v1, v2;
  logic [16:0] byte_idx;
  logic [AW-1:0] word_idx;
  logic [7:0]  csum, cur_byte;
  logic [23:0] a1, b1, mx, mn;
  logic [24:0] mag25, mag25_nx, shifted;
  logic [15:0] buffer [HALF];

  // The most negative input has no positive twin; clamp it instead of wrapping.
  function automatic logic [23:0] abs24(input logic [23:0] x);
    if (!x[23]) return x;
    if (x == 24'h800000) return 24'h7FFFFF;
    return ~x + 24'd1;
  endfunction

  assign take_first = (state == IDLE) && arm && s_tvalid;
  assign take_beat  = (state == CAPTURE) && !drain && s_tvalid;
  assign at_last    = beat_cnt == LAST_BEAT;
  assign bad_len    = (take_first && s_tlast) || (take_beat && (s_tlast != at_last));
  assign frame_end  = take_beat && s_tlast && at_last;
  assign pipe_in    = (take_first || take_beat) && !bad_len;
  assign last_byte  = byte_idx == LAST_BYTE;
  assign send_now   = (state == SEND) && !tx_busy;
  assign advance    = (state == WAITTX) && !tx_busy;
  assign in_data    = (byte_idx >= 17'd6) && (byte_idx <= DATA_END);
  assign dropped    = s_tvalid && ((state == SEND) || (state == GUARD) || (state == WAITTX) ||
                                   ((state == IDLE) && !arm));
  assign busy       = state != IDLE;

  assign mx       = (a1 > b1) ? a1 : b1;
  assign mn       = (a1 > b1) ? b1 : a1;
  assign mag25_nx = {1'b0, mx} + ({1'b0, mn} >> 1);
  assign shifted  = mag25 >> MAG_SHIFT;
  assign mag16    = (|shifted[24:16]) ? 16'hFFFF : shifted[15:0];

  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    case (state)
      IDLE:    if (take_first && !s_tlast) state_nx = CAPTURE;
      CAPTURE: begin
        if (bad_len) state_nx = IDLE;
        else if (drain && drain_cnt) state_nx = SEND;
      end
      SEND:    if (!tx_busy) state_nx = GUARD;
      GUARD:   if (guard_cnt) state_nx = WAITTX;
      WAITTX:  begin
        if (!tx_busy) begin
          if (last_byte) begin
            state_nx   = IDLE;
            frame_done = 1'b1;
          end else begin
            state_nx = SEND;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_word  = buffer[word_idx];
    cur_byte = csum;
    case (byte_idx)
      17'd0:   cur_byte = 8'hA5;
      17'd1:   cur_byte = 8'h5A;
      17'd2:   cur_byte = peak_bin[15:8];
      17'd3:   cur_byte = peak_bin[7:0];
      17'd4:   cur_byte = peak_mag[15:8];
      17'd5:   cur_byte = peak_mag[7:0];
      default: if (in_data) cur_byte = lo_sel ? rd_word[7:0] : rd_word[15:8];
    endcase
  end

  always_ff @(posedge clk_24M_from_pll or negedge rst_24M_n) begin
    if (!rst_24M_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_ff @(posedge clk_24M_from_pll) begin
    if (v2 && (bin2 < HALF_BINS)) buffer[bin2[AW-1:0]] <= mag16;
  end

  always_ff @(posedge clk_24M_from_pll or negedge rst_24M_n) begin
    if (!rst_24M_n) begin
      v1 <= 1'b0; v2 <= 1'b0; a1 <= '0; b1 <= '0; bin1 <= '0; bin2 <= '0; mag25 <= '0;
      beat_cnt <= '0; drain <= 1'b0; drain_cnt <= 1'b0; guard_cnt <= 1'b0;
      peak_bin <= '0; peak_mag <= '0; byte_idx <= '0; word_idx <= '0; lo_sel <= 1'b0;
      csum <= '0; tx_data <= '0; tx_start <= 1'b0; err_len <= 1'b0; drop_cnt <= '0;
    end else begin
      // An aborted frame must not leave in-flight beats behind for the next one.
      v1 <= pipe_in;
      v2 <= v1 && !bad_len;
      if (pipe_in) begin
        a1   <= abs24(s_tdata[23:0]);
        b1   <= abs24(s_tdata[47:24]);
        bin1 <= take_first ? 16'd0 : beat_cnt;
      end
      if (v1) begin
        mag25 <= mag25_nx;
        bin2  <= bin1;
      end
      if (take_first) begin
        peak_bin <= 16'd1;
        peak_mag <= '0;
      end else if (v2 && (bin2 != 16'd0) && (bin2 < HALF_BINS) && (mag16 > peak_mag)) begin
        peak_bin <= bin2;
        peak_mag <= mag16;
      end
      if (take_first)                 beat_cnt <= 16'd1;
      else if (take_beat && !bad_len) beat_cnt <= beat_cnt + 16'd1;
      if (take_first)     drain <= 1'b0;
      else if (frame_end) drain <= 1'b1;
      if (take_first)                         drain_cnt <= 1'b0;
      else if ((state == CAPTURE) && drain)   drain_cnt <= !drain_cnt;
      guard_cnt <= (state == GUARD) ? !guard_cnt : 1'b0;
      if (take_first) begin
        byte_idx <= '0;
        word_idx <= '0;
        lo_sel   <= 1'b0;
        csum     <= '0;
      end else begin
        if (advance && !last_byte) begin
          byte_idx <= byte_idx + 17'd1;
          if (in_data) begin
            lo_sel <= !lo_sel;
            if (lo_sel) word_idx <= word_idx + 1'b1;
          end
        end
        if (send_now && (byte_idx >= 17'd2) && !last_byte) csum <= csum ^ cur_byte;
      end
      tx_start <= send_now;
      if (send_now) tx_data <= cur_byte;
      if (bad_len) err_len <= 1'b1;
      if (dropped && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_fft_spectrum_packer.sv
// tb/tb_fft_spectrum_packer.sv - directed frame-level checks of fft_spectrum_packer
module tb_fft_spectrum_packer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, arm, s_tvalid, s_tlast, tx_busy;
  logic [47:0] s_tdata;
  logic [7:0]  tx_data, drop_cnt, tx_data2, drop_cnt2;
  logic        tx_start, busy, frame_done, err_len;
  logic        tx_start2, busy2, frame_done2, err_len2;

  fft_spectrum_packer dut (
    .clk_24M_from_pll(clk), .rst_24M_n(rstn), .arm(arm), .s_tvalid(s_tvalid),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .busy(busy), .frame_done(frame_done), .err_len(err_len),
    .drop_cnt(drop_cnt));

  // Narrow instance where MAG_SHIFT is small enough for the 16-bit clamp to engage.
  fft_spectrum_packer #(.POINTS(16), .MAG_SHIFT(7)) dut_sat (
    .clk_24M_from_pll(clk), .rst_24M_n(rstn), .arm(arm), .s_tvalid(s_tvalid),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .tx_data(tx_data2), .tx_start(tx_start2),
    .tx_busy(tx_busy), .busy(busy2), .frame_done(frame_done2), .err_len(err_len2),
    .drop_cnt(drop_cnt2));

  int n_cmp = 0, n_bad = 0, fd_cnt = 0, fd_cnt2 = 0;
  logic [7:0]  rx[$], rx2[$], exp_q[$];
  logic [23:0] re_v[int], im_v[int];
  logic [15:0] exp_mag[int];

  always @(negedge clk) begin
    if (tx_start) rx.push_back(tx_data);
    if (tx_start2) rx2.push_back(tx_data2);
    if (frame_done) fd_cnt++;
    if (frame_done2) fd_cnt2++;
  end

  function automatic logic [7:0] rx_at(int i);
    if (i < rx.size()) return rx[i];
    return 8'hxx;
  endfunction

  function automatic int frame_diff();
    int d = 0;
    if (rx.size() != exp_q.size()) d++;
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++) if (rx[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic build_exp(input int half, input logic [15:0] pbin, input logic [15:0] pmag);
    logic [7:0]  cs;
    logic [15:0] m;
    exp_q = {8'hA5, 8'h5A, pbin[15:8], pbin[7:0], pmag[15:8], pmag[7:0]};
    cs = pbin[15:8] ^ pbin[7:0] ^ pmag[15:8] ^ pmag[7:0];
    for (int b = 0; b < half; b++) begin
      m = exp_mag.exists(b) ? exp_mag[b] : 16'h0000;
      exp_q.push_back(m[15:8]);
      exp_q.push_back(m[7:0]);
      cs = cs ^ m[15:8] ^ m[7:0];
    end
    exp_q.push_back(cs);
  endtask

  task automatic clear_vectors();
    re_v.delete(); im_v.delete(); exp_mag.delete();
  endtask

  task automatic drive_frame(input int nbeats, input int tlast_at);
    logic [23:0] r, m;
    for (int i = 0; i < nbeats; i++) begin
      r = re_v.exists(i) ? re_v[i] : 24'd0;
      m = im_v.exists(i) ? im_v[i] : 24'd0;
      s_tvalid = 1'b1; s_tdata = {m, r}; s_tlast = (i == tlast_at);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start = fd_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (fd_cnt != start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] obs[6];
    string nm[6];
    nm = '{"tx_data", "tx_start", "busy", "frame_done", "err_len", "drop_cnt"};
    rstn = 1'b0;
    repeat (3) @(posedge clk); #1;
    obs = '{tx_data, {7'd0, tx_start}, {7'd0, busy}, {7'd0, frame_done}, {7'd0, err_len}, drop_cnt};
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (obs[i] !== 8'h00) begin n_bad++; $display("FAIL reset_%s: got %h want 00", nm[i], obs[i]); end
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_peak();
    bit ok;
    int fd0;
    logic [7:0] want[6];
    want = '{8'hA5, 8'h5A, 8'h00, 8'h25, 8'h00, 8'h80};
    clear_vectors(); re_v[37] = 24'h010000; exp_mag[37] = 16'h0080;
    rx.delete(); fd0 = fd_cnt; arm = 1'b1;
    drive_frame(1024, 1023);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL peak_busy_after_capture: got %b want 1", busy); end
    wait_done(6000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL peak_done_timeout: got no frame_done want frame_done"); end
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_bad++; $display("FAIL peak_frame_done_count: got %0d want 1", fd_cnt - fd0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL peak_busy_end: got %b want 0", busy); end
    n_cmp++; if (rx.size() != 1031) begin n_bad++; $display("FAIL peak_byte_count: got %0d want 1031", rx.size()); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (rx_at(i) !== want[i]) begin n_bad++; $display("FAIL peak_hdr%0d: got %h want %h", i, rx_at(i), want[i]); end
    end
    n_cmp++; if ({rx_at(80), rx_at(81)} !== 16'h0080) begin n_bad++; $display("FAIL peak_bin37: got %h%h want 0080", rx_at(80), rx_at(81)); end
    n_cmp++; if (rx_at(1030) !== 8'h25) begin n_bad++; $display("FAIL peak_checksum: got %h want 25", rx_at(1030)); end
    build_exp(512, 16'd37, 16'h0080);
    n_cmp++; if (frame_diff() != 0) begin n_bad++; $display("FAIL peak_frame_bytes: got %0d differing want 0", frame_diff()); end
  endtask

  // At MAG_SHIFT=9 the worst-case 0xBFFFFE only reaches 0x5FFF.
  task automatic test_mag_math();
    bit ok;
    clear_vectors();
    re_v[5] = 24'h800000; im_v[5] = 24'h800000; exp_mag[5] = 16'h5FFF;
    re_v[10] = 24'hFFFC00; im_v[10] = 24'h000200; exp_mag[10] = 16'h0002;
    rx.delete(); arm = 1'b1;
    drive_frame(1024, 1023);
    wait_done(6000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mag_done_timeout: got no frame_done want frame_done"); end
    n_cmp++; if ({rx_at(2), rx_at(3), rx_at(4), rx_at(5)} !== 32'h00055FFF) begin
      n_bad++; $display("FAIL mag_peak: got %h%h%h%h want 00055FFF", rx_at(2), rx_at(3), rx_at(4), rx_at(5)); end
    n_cmp++; if ({rx_at(16), rx_at(17)} !== 16'h5FFF) begin n_bad++; $display("FAIL mag_bin5: got %h%h want 5FFF", rx_at(16), rx_at(17)); end
    n_cmp++; if ({rx_at(26), rx_at(27)} !== 16'h0002) begin n_bad++; $display("FAIL mag_bin10: got %h%h want 0002", rx_at(26), rx_at(27)); end
    n_cmp++; if (rx_at(1030) !== 8'h07) begin n_bad++; $display("FAIL mag_checksum: got %h want 07", rx_at(1030)); end
    build_exp(512, 16'd5, 16'h5FFF);
    n_cmp++; if (frame_diff() != 0) begin n_bad++; $display("FAIL mag_frame_bytes: got %0d differing want 0", frame_diff()); end
  endtask

  task automatic test_len_error_then_tie();
    bit ok;
    clear_vectors(); rx.delete(); arm = 1'b1;
    drive_frame(501, 500);
    repeat (20) @(posedge clk); #1;
    n_cmp++; if (err_len !== 1'b1) begin n_bad++; $display("FAIL len_err_flag: got %b want 1", err_len); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL len_busy: got %b want 0", busy); end
    n_cmp++; if (rx.size() != 0) begin n_bad++; $display("FAIL len_no_tx: got %0d bytes want 0", rx.size()); end
    re_v[3] = 24'h020000; exp_mag[3] = 16'h0100;
    re_v[7] = 24'h01FE00; exp_mag[7] = 16'h00FF;
    re_v[9] = 24'h020000; exp_mag[9] = 16'h0100;
    drive_frame(1024, 1023);
    wait_done(6000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tie_done_timeout: got no frame_done want frame_done"); end
    n_cmp++; if ({rx_at(2), rx_at(3), rx_at(4), rx_at(5)} !== 32'h00030100) begin
      n_bad++; $display("FAIL tie_peak: got %h%h%h%h want 00030100", rx_at(2), rx_at(3), rx_at(4), rx_at(5)); end
    n_cmp++; if (rx_at(1030) !== 8'hFD) begin n_bad++; $display("FAIL tie_checksum: got %h want FD", rx_at(1030)); end
    build_exp(512, 16'd3, 16'h0100);
    n_cmp++; if (frame_diff() != 0) begin n_bad++; $display("FAIL tie_frame_bytes: got %0d differing want 0", frame_diff()); end
    n_cmp++; if (err_len !== 1'b1) begin n_bad++; $display("FAIL len_err_sticky: got %b want 1", err_len); end
  endtask

  task automatic test_dc_only();
    bit ok;
    clear_vectors(); re_v[0] = 24'h100000; exp_mag[0] = 16'h0800;
    rx.delete(); arm = 1'b1;
    drive_frame(1024, 1023);
    wait_done(6000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL dc_done_timeout: got no frame_done want frame_done"); end
    n_cmp++; if ({rx_at(2), rx_at(3), rx_at(4), rx_at(5)} !== 32'h00010000) begin
      n_bad++; $display("FAIL dc_peak: got %h%h%h%h want 00010000", rx_at(2), rx_at(3), rx_at(4), rx_at(5)); end
    n_cmp++; if ({rx_at(6), rx_at(7)} !== 16'h0800) begin n_bad++; $display("FAIL dc_bin0: got %h%h want 0800", rx_at(6), rx_at(7)); end
    n_cmp++; if (rx_at(1030) !== 8'h09) begin n_bad++; $display("FAIL dc_checksum: got %h want 09", rx_at(1030)); end
  endtask

  task automatic test_drops();
    bit ok;
    n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL drop_start: got %0d want 0", drop_cnt); end
    clear_vectors(); re_v[37] = 24'h010000; exp_mag[37] = 16'h0080;
    rx.delete(); arm = 1'b1;
    drive_frame(1024, 1023);
    for (int i = 0; i < 20 && rx.size() == 0; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 300; i++) begin
      s_tvalid = 1'b1; s_tdata = {24'(i * 7), 24'(i * 1031)}; s_tlast = (i % 7 == 0);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    n_cmp++; if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt); end
    wait_done(6000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop_done_timeout: got no frame_done want frame_done"); end
    build_exp(512, 16'd37, 16'h0080);
    n_cmp++; if (frame_diff() != 0) begin n_bad++; $display("FAIL drop_frame_bytes: got %0d differing want 0", frame_diff()); end
    n_cmp++; if (rx_at(1030) !== 8'h25) begin n_bad++; $display("FAIL drop_checksum: got %h want 25", rx_at(1030)); end
  endtask

  task automatic test_busy_hold_and_reset();
    logic [7:0] obs[6];
    string nm[6];
    nm = '{"tx_data", "tx_start", "busy", "frame_done", "err_len", "drop_cnt"};
    clear_vectors(); rx.delete(); arm = 1'b1;
    drive_frame(1024, 1023);
    for (int i = 0; i < 50 && rx.size() == 0; i++) begin @(posedge clk); #1; end
    tx_busy = 1'b1;
    repeat (1000) @(posedge clk); #1;
    n_cmp++; if (rx.size() != 1) begin n_bad++; $display("FAIL hold_no_second_start: got %0d starts want 1", rx.size()); end
    tx_busy = 1'b0;
    for (int i = 0; i < 10 && rx.size() < 2; i++) begin @(posedge clk); #1; end
    n_cmp++; if (rx_at(1) !== 8'h5A) begin n_bad++; $display("FAIL hold_resume: got %h want 5A", rx_at(1)); end
    #2 rstn = 1'b0;
    #1;
    obs = '{tx_data, {7'd0, tx_start}, {7'd0, busy}, {7'd0, frame_done}, {7'd0, err_len}, drop_cnt};
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (obs[i] !== 8'h00) begin n_bad++; $display("FAIL midsend_reset_%s: got %h want 00", nm[i], obs[i]); end
    end
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    repeat (100) @(posedge clk); #1;
    n_cmp++; if (rx.size() != 2) begin n_bad++; $display("FAIL post_reset_silent: got %0d bytes want 2", rx.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_saturation();
    logic [7:0] want[23];
    int fd0;
    want = '{8'hA5, 8'h5A, 8'h00, 8'h05, 8'hFF, 8'hFF,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00,
             8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0D};
    clear_vectors();
    re_v[5] = 24'h800000; im_v[5] = 24'h800000; re_v[2] = 24'h000400;
    rx2.delete(); fd0 = fd_cnt2; arm = 1'b1;
    drive_frame(16, 15);
    for (int i = 0; i < 400 && fd_cnt2 == fd0; i++) begin @(posedge clk); #1; end
    n_cmp++; if (fd_cnt2 - fd0 != 1) begin n_bad++; $display("FAIL sat_frame_done: got %0d want 1", fd_cnt2 - fd0); end
    n_cmp++; if (rx2.size() != 23) begin n_bad++; $display("FAIL sat_byte_count: got %0d want 23", rx2.size()); end
    for (int i = 0; i < 23; i++) begin
      n_cmp++;
      if (i >= rx2.size() || rx2[i] !== want[i]) begin
        n_bad++; $display("FAIL sat_byte%0d: got %h want %h", i, (i < rx2.size()) ? rx2[i] : 8'hxx, want[i]);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; arm = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; tx_busy = 1'b0;
    test_reset();
    test_single_peak();
    test_mag_math();
    test_len_error_then_tie();
    test_dc_only();
    test_drops();
    test_busy_hold_and_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
